// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode/funct3/ALU constants, control bundle and decode helper
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_FULL} occ_e;

  typedef struct packed {
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    out_ctr;
    logic    alu_in_ctr;
    logic    branch;
    logic    jump;
    logic    illegal;
    alu_op_e alu;
    logic [2:0] br_cond;
  } ctrl_t;

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // rv64 widens shift amounts to 6 bits and admits the doubleword load/store widths
  function automatic ctrl_t decode(input logic [31:0] inst, input logic rv64);
    ctrl_t      c;
    logic       ok;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = inst[14:12];
    f7 = inst[31:25];
    c = '0;
    c.alu = ALU_ADD;
    c.br_cond = f3;
    ok = 1'b1;
    case (inst[6:0])
      OP_R: begin
        c.reg_write = 1'b1;
        if (f7 == 7'b0000000)
          c.alu = alu_from_f3(f3, 1'b0);
        else if (f7 == 7'b0100000 && (f3 == F3_ADD || f3 == F3_SR))
          c.alu = alu_from_f3(f3, 1'b1);
        else
          ok = 1'b0;
      end
      OP_IMM: begin
        c.reg_write  = 1'b1;
        c.alu_in_ctr = 1'b1;
        c.alu = alu_from_f3(f3, 1'b0);
        if (f3 == F3_SLL)
          ok = (inst[31:26] == 6'b0) && (rv64 || !inst[25]);
        else if (f3 == F3_SR) begin
          ok = (inst[31:26] == 6'b0 || inst[31:26] == 6'b010000) && (rv64 || !inst[25]);
          c.alu = alu_from_f3(f3, inst[30]);
        end
      end
      OP_LOAD: begin
        c.mem_read   = 1'b1;
        c.reg_write  = 1'b1;
        c.out_ctr    = 1'b1;
        c.alu_in_ctr = 1'b1;
        ok = (f3 != 3'd7) && (rv64 || (f3 != 3'd3 && f3 != 3'd6));
      end
      OP_STORE: begin
        c.mem_write  = 1'b1;
        c.alu_in_ctr = 1'b1;
        ok = (f3 < 3'd3) || (rv64 && f3 == 3'd3);
      end
      OP_BRANCH: begin
        c.branch = 1'b1;
        c.alu    = ALU_SUB;
        ok = (f3 != 3'd2) && (f3 != 3'd3);
      end
      OP_LUI, OP_AUIPC: begin
        c.reg_write  = 1'b1;
        c.alu_in_ctr = 1'b1;
      end
      OP_JAL: begin
        c.jump      = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_JALR: begin
        c.jump      = 1'b1;
        c.reg_write = 1'b1;
        ok = (f3 == 3'd0);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      c = '0;
      c.alu     = ALU_ADD;
      c.illegal = 1'b1;
      c.br_cond = f3;
    end
    return c;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational I/S/B/U/J immediate extraction, sign-extended to XLEN
module imm_gen
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:                 imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:                imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm32 = {inst[31:12], 12'b0};
      OP_JAL:                   imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default:                  imm32 = '0;
    endcase
  end

  // every format is 32 bits wide with bit 31 = INST[31], so one widening covers all
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - one-cycle instruction decoder with output and skid registers
module decode_pipe
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ALU_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      INST,
  input  logic [XLEN-1:0]  pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  pc_out,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             out_ctr,
  output logic             alu_in_ctr,
  output logic             branch,
  output logic             jump,
  output logic             illegal,
  output logic [ALU_W-1:0] alu_ctr,
  output logic [2:0]       br_cond,
  output logic [XLEN-1:0]  ext_out
);

  typedef struct packed {
    ctrl_t           ctrl;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } entry_t;

  occ_e            state_q, state_d;
  entry_t          dec_entry, out_q, skid_q, shown;
  logic [XLEN-1:0] imm;
  logic            in_fire, out_fire;
  logic            load_out, out_from_skid, load_skid;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (INST),
    .imm  (imm)
  );

  assign dec_entry = '{ctrl: decode(INST, XLEN == 64), imm: imm, pc: pc_in};

  // in_ready depends only on registered occupancy, never on out_ready
  assign in_ready  = reset && (state_q != OCC_FULL);
  assign out_valid = (state_q != OCC_EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= OCC_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    out_from_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            load_out = 1'b1;
            state_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            load_out = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_d   = OCC_FULL;
          end else if (out_fire) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (out_fire) begin
            load_out      = 1'b1;
            out_from_skid = 1'b1;
            state_d       = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out)  out_q  <= out_from_skid ? skid_q : dec_entry;
      if (load_skid) skid_q <= dec_entry;
    end
  end

  // stale register contents never leak out while nothing is valid
  assign shown = out_valid ? out_q : '0;

  assign pc_out     = shown.pc;
  assign ext_out    = shown.imm;
  assign mem_read   = shown.ctrl.mem_read;
  assign mem_write  = shown.ctrl.mem_write;
  assign reg_write  = shown.ctrl.reg_write;
  assign out_ctr    = shown.ctrl.out_ctr;
  assign alu_in_ctr = shown.ctrl.alu_in_ctr;
  assign branch     = shown.ctrl.branch;
  assign jump       = shown.ctrl.jump;
  assign illegal    = shown.ctrl.illegal;
  assign alu_ctr    = ALU_W'(shown.ctrl.alu);
  assign br_cond    = shown.ctrl.br_cond;

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - directed vector bench for decode_pipe at XLEN 32 and 64
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] inst;
  logic [63:0] pc;

  logic        a_in_ready, a_out_valid, a_mr, a_mw, a_rw, a_oc, a_ai, a_br, a_j, a_il;
  logic [31:0] a_pc_out, a_ext;
  logic [3:0]  a_alu;
  logic [2:0]  a_brc;

  logic        b_in_ready, b_out_valid, b_mr, b_mw, b_rw, b_oc, b_ai, b_br, b_j, b_il;
  logic [63:0] b_pc_out, b_ext;
  logic [3:0]  b_alu;
  logic [2:0]  b_brc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_pipe #(.XLEN(32), .ALU_W(4)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .INST(inst), .pc_in(pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .pc_out(a_pc_out), .mem_read(a_mr), .mem_write(a_mw), .reg_write(a_rw), .out_ctr(a_oc),
    .alu_in_ctr(a_ai), .branch(a_br), .jump(a_j), .illegal(a_il), .alu_ctr(a_alu),
    .br_cond(a_brc), .ext_out(a_ext)
  );

  decode_pipe #(.XLEN(64), .ALU_W(4)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .INST(inst), .pc_in(pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .pc_out(b_pc_out), .mem_read(b_mr), .mem_write(b_mw), .reg_write(b_rw), .out_ctr(b_oc),
    .alu_in_ctr(b_ai), .branch(b_br), .jump(b_j), .illegal(b_il), .alu_ctr(b_alu),
    .br_cond(b_brc), .ext_out(b_ext)
  );

  typedef struct {
    logic [31:0] inst;
    logic [7:0]  flags;
    logic [3:0]  alu;
    logic [2:0]  brc;
    logic [31:0] ext32;
    logic [63:0] ext64;
  } vec_t;

  vec_t        vecs[18];
  logic [15:0] got[$];
  logic        rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] a_flags();
    return {a_mr, a_mw, a_rw, a_oc, a_ai, a_br, a_j, a_il};
  endfunction

  function automatic logic [7:0] b_flags();
    return {b_mr, b_mw, b_rw, b_oc, b_ai, b_br, b_j, b_il};
  endfunction

  initial begin
    // flags = {mem_read, mem_write, reg_write, out_ctr, alu_in_ctr, branch, jump, illegal}
    // alu: ADD=0 SUB=1 SLL=2 SRA=7 AND=9
    vecs[0]  = '{32'h00500093, 8'b0010_1000, 4'd0, 3'd0, 32'h00000005, 64'h0000000000000005};
    vecs[1]  = '{32'hFE000EE3, 8'b0000_0100, 4'd1, 3'd0, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC};
    vecs[2]  = '{32'h12345037, 8'b0010_1000, 4'd0, 3'd5, 32'h12345000, 64'h0000000012345000};
    vecs[3]  = '{32'h80000037, 8'b0010_1000, 4'd0, 3'd0, 32'h80000000, 64'hFFFFFFFF80000000};
    vecs[4]  = '{32'h0000007F, 8'b0000_0001, 4'd0, 3'd0, 32'h00000000, 64'h0000000000000000};
    vecs[5]  = '{32'hFF812083, 8'b1011_1000, 4'd0, 3'd2, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8};
    vecs[6]  = '{32'h00512A23, 8'b0100_1000, 4'd0, 3'd2, 32'h00000014, 64'h0000000000000014};
    vecs[7]  = '{32'h001000EF, 8'b0010_0010, 4'd0, 3'd0, 32'h00000800, 64'h0000000000000800};
    vecs[8]  = '{32'h00008067, 8'b0010_0010, 4'd0, 3'd0, 32'h00000000, 64'h0000000000000000};
    vecs[9]  = '{32'hFFFFF197, 8'b0010_1000, 4'd0, 3'd7, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000};
    vecs[10] = '{32'h402081B3, 8'b0010_0000, 4'd1, 3'd0, 32'h00000000, 64'h0000000000000000};
    vecs[11] = '{32'h4020D1B3, 8'b0010_0000, 4'd7, 3'd5, 32'h00000000, 64'h0000000000000000};
    vecs[12] = '{32'h0020F1B3, 8'b0010_0000, 4'd9, 3'd7, 32'h00000000, 64'h0000000000000000};
    vecs[13] = '{32'h4020F1B3, 8'b0000_0001, 4'd0, 3'd7, 32'h00000000, 64'h0000000000000000};
    vecs[14] = '{32'h00002063, 8'b0000_0001, 4'd0, 3'd2, 32'h00000000, 64'h0000000000000000};
    vecs[15] = '{32'h0020E463, 8'b0000_0100, 4'd1, 3'd6, 32'h00000008, 64'h0000000000000008};
    vecs[16] = '{32'h00309093, 8'b0010_1000, 4'd2, 3'd1, 32'h00000003, 64'h0000000000000003};
    vecs[17] = '{32'h4020D093, 8'b0010_1000, 4'd7, 3'd5, 32'h00000402, 64'h0000000000000402};

    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    inst = 32'h00500093; pc = 64'h100;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_in_ready",  a_in_ready,  1'b0);
    chk("rst_pc_out",    a_pc_out,    32'h0);
    chk("rst_ext",       a_ext,       32'h0);
    chk("rst_flags",     a_flags(),   8'h0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rel_in_ready",  a_in_ready,  1'b1);
    chk("rel_out_valid", a_out_valid, 1'b0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      inst = vecs[i].inst;
      pc = 64'h1000 + 64'(i * 4);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), a_out_valid, 1'b1);
      chk($sformatf("v%0d_pc", i),    a_pc_out,    32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d_flags", i), a_flags(),   vecs[i].flags);
      chk($sformatf("v%0d_alu", i),   a_alu,       vecs[i].alu);
      chk($sformatf("v%0d_brc", i),   a_brc,       vecs[i].brc);
      chk($sformatf("v%0d_ext32", i), a_ext,       vecs[i].ext32);
      chk($sformatf("v%0d_ext64", i), b_ext,       vecs[i].ext64);
      chk($sformatf("v%0d_flags64", i), b_flags(), vecs[i].flags);
    end
    @(negedge clk);
    chk("idle_valid", a_out_valid, 1'b0);
    chk("idle_flags", a_flags(),   8'h0);
    chk("idle_ext",   a_ext,       32'h0);

    // backpressure: three back-to-back offers while the consumer stalls
    inst = 32'h00500093;
    out_ready = 1'b0; in_valid = 1'b1; pc = 64'h2000;
    @(negedge clk);
    chk("bp_valid1", a_out_valid, 1'b1);
    chk("bp_ready1", a_in_ready,  1'b1);
    pc = 64'h2004;
    @(negedge clk);
    chk("bp_ready2", a_in_ready, 1'b0);
    chk("bp_hold1",  a_pc_out,   32'h2000);
    pc = 64'h2008;
    @(negedge clk);
    chk("bp_ready3", a_in_ready, 1'b0);
    chk("bp_hold2",  a_pc_out,   32'h2000);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rdy = a_in_ready;
      if (a_out_valid) got.push_back(a_pc_out[15:0]);
      @(posedge clk);
      #1;
      if (in_valid && rdy) in_valid = 1'b0;
      @(negedge clk);
    end
    chk("bp_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("bp_order0", got[0], 16'h2000);
      chk("bp_order1", got[1], 16'h2004);
      chk("bp_order2", got[2], 16'h2008);
    end

    // flush while full, with a simultaneous offer and consumer ready
    out_ready = 1'b0; in_valid = 1'b1; pc = 64'h3000;
    @(negedge clk);
    pc = 64'h3004;
    @(negedge clk);
    chk("fl_full", a_in_ready, 1'b0);
    flush = 1'b1; out_ready = 1'b1; pc = 64'h3008;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", a_out_valid, 1'b0);
    chk("fl_ready", a_in_ready,  1'b1);
    chk("fl_ext",   a_ext,       32'h0);
    chk("fl_flags", a_flags(),   8'h0);
    @(negedge clk);
    chk("fl_dropped", a_out_valid, 1'b0);

    // reset asserted while full
    out_ready = 1'b0; in_valid = 1'b1; inst = 32'hFF812083; pc = 64'h4000;
    @(negedge clk);
    pc = 64'h4004;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rs_full", a_in_ready, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("rs_valid",    a_out_valid, 1'b0);
    chk("rs_pc",       a_pc_out,    32'h0);
    chk("rs_ext",      a_ext,       32'h0);
    chk("rs_flags",    a_flags(),   8'h0);
    chk("rs_in_ready", a_in_ready,  1'b0);
    chk("rs_ext64",    b_ext,       64'h0);
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1; inst = 32'h00500093; pc = 64'h5000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rs_after_valid", a_out_valid, 1'b1);
    chk("rs_after_pc",    a_pc_out,    32'h5000);
    chk("rs_after_ext",   a_ext,       32'h5);
    @(negedge clk);
    chk("rs_no_stale", a_out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath/immediate width; legal values 32 or 64.
REQ-002 Parameter ALU_W, default 4, width of the ALU operation code.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 flush  input  1  synchronous kill of all held instructions.
REQ-006 in_valid  input  1  INST/pc_in carry an instruction.
REQ-007 in_ready  output  1  block accepts an instruction this cycle.
REQ-008 INST  input  32  instruction word.
REQ-009 pc_in  input  XLEN  instruction address.
REQ-010 out_valid  output  1  decoded bundle valid.
REQ-011 out_ready  input  1  consumer accepts the bundle this cycle.
REQ-012 pc_out  output  XLEN  address of the decoded instruction.
REQ-013 mem_read, mem_write, reg_write, out_ctr, alu_in_ctr, branch, jump, illegal  output  1 each  control flags.
REQ-014 alu_ctr  output  ALU_W  ALU operation.
REQ-015 br_cond  output  3  branch condition (funct3).
REQ-016 ext_out  output  XLEN  sign-extended immediate.

Function
REQ-017 Transfers occur only when valid and ready are both 1 on a rising edge.
REQ-018 Latency is exactly one cycle: an instruction accepted at edge N is presented on the outputs after edge N.
REQ-019 Storage is one output register plus one skid register, giving full throughput with no combinational path from out_ready to in_ready.
REQ-020 in_ready = 1 exactly when the skid register is empty.
REQ-021 When out_valid=1 and out_ready=0, the outputs hold stable; a newly accepted instruction goes to the skid register.
REQ-022 On an output transfer, the skid entry (if any) moves to the output register before any new input is considered; order is strictly preserved.
REQ-023 Occupancy states are EMPTY, ONE and FULL; transitions: accept-only +1, transfer-only -1, both unchanged; in FULL, in_ready=0.
REQ-024 flush=1 invalidates both entries at the next edge and drops any input offered in that cycle; out_valid=0 and in_ready=1 follow; flush overrides simultaneous accept and transfer.
REQ-025 Decoded opcodes: R (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND), OP-IMM (same set except SUB), LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR.
REQ-026 ALU for LOAD/STORE/AUIPC/JAL/JALR/LUI is ADD; for BRANCH it is SUB; br_cond = INST[14:12].
REQ-027 LOAD sets mem_read, reg_write, out_ctr and alu_in_ctr; STORE sets mem_write and alu_in_ctr; JAL/JALR set jump and reg_write; LUI, AUIPC and OP-IMM set reg_write and alu_in_ctr.
REQ-028 Immediate formats I, S, B, U and J are sign-extended from INST[31] to XLEN; B and J have bit 0 = 0; U is INST[31:12] followed by 12 zeros; R type gives 0.
REQ-029 Unknown opcodes or funct3/funct7 combinations set illegal=1 and force mem_read, mem_write, reg_write, branch and jump to 0; the entry still flows through the pipe.
REQ-030 When out_valid=0, all control flags are 0 and ext_out = 0.

Reset
REQ-031 While reset=0, occupancy is EMPTY, out_valid=0, in_ready=0, and all flags, alu_ctr, br_cond, ext_out and pc_out are 0.
REQ-032 Assertion mid-operation discards all held instructions immediately; in_ready=1 from the first edge after release.

Structure
REQ-033 Opcode, funct3 and ALU-op constants and the decoded control-bundle struct live in the shared package cpu_pkg.
REQ-034 Immediate generation is a combinational sub-module imm_gen, parametrised by XLEN; control decode is combinational ahead of the skid/output registers.

Verification
REQ-035 addi x1,x0,5 (0x00500093) with out_ready=1 -> one cycle later: out_valid=1, alu_ctr=ADD, alu_in_ctr=1, reg_write=1, ext_out=0x00000005.
REQ-036 beq x0,x0,-4 (0xFE000EE3) -> branch=1, alu_ctr=SUB, br_cond=0, ext_out=0xFFFFFFFC.
REQ-037 lui (0x12345037) at XLEN=64 -> ext_out=0x0000000012345000; a lui with INST[31]=1 must sign-extend.
REQ-038 out_ready=0 for 3 cycles with 3 back-to-back inputs -> in_ready drops after the 2nd accept; after out_ready=1, all three emerge in order, none lost or duplicated.
REQ-039 0x0000007F -> illegal=1, reg_write=0, mem_write=0; flush while FULL -> out_valid=0 next cycle, in_ready=1.
REQ-040 reset=0 asserted while FULL -> outputs zero immediately; after release, the first accepted instruction appears one cycle later.
